// File: rtl/fp_mon_pkg.sv
// Shared types and constants for the IEEE-754 exception-flag monitor:
// rounding modes, rule indices, fflags bit positions and value classification.
package fp_mon_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RNA = 3'd1,
    RM_RTP = 3'd2,
    RM_RTN = 3'd3,
    RM_RTZ = 3'd4
  } rmode_e;

  localparam int R0  = 0;
  localparam int R1  = 1;
  localparam int R2  = 2;
  localparam int R3  = 3;
  localparam int R4  = 4;
  localparam int R5  = 5;
  localparam int R6  = 6;
  localparam int R7  = 7;
  localparam int R8  = 8;
  localparam int R9  = 9;
  localparam int R10 = 10;
  localparam int NUM_RULES = 11;

  localparam int FL_NV = 4;
  localparam int FL_DZ = 3;
  localparam int FL_OF = 2;
  localparam int FL_UF = 1;
  localparam int FL_NX = 0;

  typedef struct packed {
    logic sign;
    logic zero;
    logic sub;
    logic norm;
    logic inf;
    logic qnan;
    logic snan;
    logic maxfin;
  } fp_class_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } mon_state_e;

  // Format-independent: callers reduce the exponent/fraction fields to these bits.
  function automatic fp_class_t classify(input logic sign, input logic exp_zero,
                                         input logic exp_ones, input logic exp_max_m1,
                                         input logic frac_zero, input logic frac_msb,
                                         input logic frac_ones);
    fp_class_t cls;
    cls.sign   = sign;
    cls.zero   = exp_zero & frac_zero;
    cls.sub    = exp_zero & ~frac_zero;
    cls.norm   = ~exp_zero & ~exp_ones;
    cls.inf    = exp_ones & frac_zero;
    cls.qnan   = exp_ones & frac_msb;
    cls.snan   = exp_ones & ~frac_msb & ~frac_zero;
    cls.maxfin = exp_max_m1 & frac_ones;
    return cls;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Splits one floating-point value into its fields and classifies it.
module fp_classify
  import fp_mon_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic [EXP_W+FRAC_W:0] value,
  output fp_class_t             cls
);

  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac_f;
  logic [EXP_W-1:0]  exp_max_m1;

  assign exp_f      = value[FRAC_W +: EXP_W];
  assign frac_f     = value[FRAC_W-1:0];
  assign exp_max_m1 = {{(EXP_W-1){1'b1}}, 1'b0};

  assign cls = classify(value[EXP_W+FRAC_W], exp_f == '0, &exp_f, exp_f == exp_max_m1,
                        frac_f == '0, frac_f[FRAC_W-1], &frac_f);

endmodule

// File: rtl/fp_flag_monitor.sv
// Two-stage exception-flag monitor: stage 1 registers the transaction and its
// classes, stage 2 registers rule results; sticky flags/counters/capture follow.
module fp_flag_monitor
  import fp_mon_pkg::*;
#(
  parameter int          EXP_W        = 8,
  parameter int          FRAC_W       = 23,
  parameter int          RMODE        = 0,
  parameter logic [10:0] RULE_EN      = 11'h7FF,
  parameter bit          HALT_ON_VIOL = 1'b0,
  parameter int          CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // valid/ready: a transaction moves only on a clock edge where in_valid && in_ready.
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   a,
  input  logic [EXP_W+FRAC_W:0]   b,
  input  logic [EXP_W+FRAC_W:0]   c,
  input  logic [EXP_W+FRAC_W:0]   result,
  input  logic [4:0]              flags,
  input  logic                    fflags_clr,
  input  logic                    viol_ack,
  output logic [4:0]              fflags,
  output logic                    viol_valid,
  output logic [3:0]              viol_code,
  output logic [EXP_W+FRAC_W:0]   viol_result,
  output logic [CNT_W-1:0]        viol_count,
  output logic [CNT_W-1:0]        txn_count,
  output logic                    fsm_state
);

  localparam rmode_e RM = rmode_e'(RMODE[2:0]);

  fp_class_t cls_a, cls_b, cls_c, cls_r;
  fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_a (.value(a),      .cls(cls_a));
  fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_b (.value(b),      .cls(cls_b));
  fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_c (.value(c),      .cls(cls_c));
  fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_r (.value(result), .cls(cls_r));

  mon_state_e state;
  logic accept;
  logic s1_valid;
  fp_class_t s1_ca, s1_cb, s1_cc, s1_cr;
  logic [4:0] s1_flags;
  logic [EXP_W+FRAC_W:0] s1_result;

  logic s2_valid, s2_viol, s2_hit;
  logic [3:0] s2_code;
  logic [4:0] s2_flags;
  logic [EXP_W+FRAC_W:0] s2_result;

  logic any_nan, any_snan, all_qnan, r_nan, of_res_ok;
  logic [NUM_RULES-1:0] fail, masked;
  logic [3:0] code_nxt;

  assign s2_hit    = s2_valid && s2_viol;
  assign in_ready  = rst_n && (HALT_ON_VIOL ? (state == ST_RUN) && !s2_hit : 1'b1);
  assign accept    = in_valid && in_ready;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_ca     <= '0;
      s1_cb     <= '0;
      s1_cc     <= '0;
      s1_cr     <= '0;
      s1_flags  <= '0;
      s1_result <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_ca     <= cls_a;
        s1_cb     <= cls_b;
        s1_cc     <= cls_c;
        s1_cr     <= cls_r;
        s1_flags  <= flags;
        s1_result <= result;
      end
    end
  end

  always_comb begin
    any_nan  = s1_ca.qnan | s1_ca.snan | s1_cb.qnan | s1_cb.snan | s1_cc.qnan | s1_cc.snan;
    any_snan = s1_ca.snan | s1_cb.snan | s1_cc.snan;
    all_qnan = s1_ca.qnan & s1_cb.qnan & s1_cc.qnan;
    r_nan    = s1_cr.qnan | s1_cr.snan;
    // Directed modes overflow to maxfin on the side they round away from.
    case (RM)
      RM_RTP:  of_res_ok = s1_cr.sign ? s1_cr.maxfin : s1_cr.inf;
      RM_RTN:  of_res_ok = s1_cr.sign ? s1_cr.inf : s1_cr.maxfin;
      RM_RTZ:  of_res_ok = s1_cr.maxfin;
      default: of_res_ok = s1_cr.inf;
    endcase
    fail      = '0;
    fail[R0]  = any_nan & ~r_nan;
    fail[R1]  = any_snan & ~s1_flags[FL_NV];
    fail[R2]  = all_qnan & s1_flags[FL_NV];
    fail[R3]  = s1_flags[FL_DZ] & ~s1_cr.inf;
    fail[R4]  = s1_flags[FL_NV] & ~s1_cr.qnan;
    fail[R5]  = s1_flags[FL_OF] & ~s1_flags[FL_NX];
    fail[R6]  = s1_flags[FL_UF] & ~s1_flags[FL_NX];
    fail[R7]  = s1_flags[FL_OF] & ~of_res_ok;
    fail[R8]  = s1_flags[FL_UF] & ~s1_cr.sub;
    fail[R9]  = s1_cr.inf & ~s1_flags[FL_OF] & s1_flags[FL_NX];
    fail[R10] = s1_cr.sub & ~s1_flags[FL_UF] & s1_flags[FL_NX];
    masked    = fail & RULE_EN;
    code_nxt  = '0;
    for (int k = NUM_RULES - 1; k >= 0; k--) begin
      if (masked[k]) code_nxt = 4'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_viol   <= 1'b0;
      s2_code   <= '0;
      s2_flags  <= '0;
      s2_result <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_viol  <= s1_valid && (|masked);
      if (s1_valid) begin
        s2_code   <= code_nxt;
        s2_flags  <= s1_flags;
        s2_result <= s1_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags      <= '0;
      viol_valid  <= 1'b0;
      viol_code   <= '0;
      viol_result <= '0;
      viol_count  <= '0;
      txn_count   <= '0;
      state       <= ST_RUN;
    end else begin
      fflags <= (fflags_clr ? 5'b0 : fflags) | (s2_valid ? s2_flags : 5'b0);
      if (s2_valid && txn_count != '1) txn_count <= txn_count + CNT_W'(1);
      if (s2_hit && viol_count != '1) viol_count <= viol_count + CNT_W'(1);
      // An ack in the same cycle as a new violation frees the slot for it.
      if (s2_hit && (!viol_valid || viol_ack)) begin
        viol_valid  <= 1'b1;
        viol_code   <= s2_code;
        viol_result <= s2_result;
      end else if (viol_ack) begin
        viol_valid <= 1'b0;
      end
      case (state)
        ST_RUN:    if (HALT_ON_VIOL && s2_hit) state <= ST_HALTED;
        ST_HALTED: if (viol_ack) state <= ST_RUN;
        default:   state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_flag_monitor.sv
// Directed bench for fp_flag_monitor: four float32 instances (RNE, RNE+halt,
// RTZ, 4-bit counters) share one stimulus stream.
module tb_fp_flag_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic [31:0] a = '0, b = '0, c = '0, result = '0;
  logic [4:0]  flags = '0;
  logic        fflags_clr = 1'b0, viol_ack = 1'b0;

  logic        in_ready_o    [4];
  logic [4:0]  fflags_o      [4];
  logic        viol_valid_o  [4];
  logic [3:0]  viol_code_o   [4];
  logic [31:0] viol_result_o [4];
  logic [15:0] viol_count_o  [3];
  logic [15:0] txn_count_o   [3];
  logic [3:0]  viol_count3, txn_count3;
  logic        fsm_state_o   [4];

  fp_flag_monitor u_rne (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o[0]),
    .a(a), .b(b), .c(c), .result(result), .flags(flags),
    .fflags_clr(fflags_clr), .viol_ack(viol_ack), .fflags(fflags_o[0]),
    .viol_valid(viol_valid_o[0]), .viol_code(viol_code_o[0]), .viol_result(viol_result_o[0]),
    .viol_count(viol_count_o[0]), .txn_count(txn_count_o[0]), .fsm_state(fsm_state_o[0]));

  fp_flag_monitor #(.HALT_ON_VIOL(1'b1)) u_halt (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o[1]),
    .a(a), .b(b), .c(c), .result(result), .flags(flags),
    .fflags_clr(fflags_clr), .viol_ack(viol_ack), .fflags(fflags_o[1]),
    .viol_valid(viol_valid_o[1]), .viol_code(viol_code_o[1]), .viol_result(viol_result_o[1]),
    .viol_count(viol_count_o[1]), .txn_count(txn_count_o[1]), .fsm_state(fsm_state_o[1]));

  fp_flag_monitor #(.RMODE(4)) u_rtz (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o[2]),
    .a(a), .b(b), .c(c), .result(result), .flags(flags),
    .fflags_clr(fflags_clr), .viol_ack(viol_ack), .fflags(fflags_o[2]),
    .viol_valid(viol_valid_o[2]), .viol_code(viol_code_o[2]), .viol_result(viol_result_o[2]),
    .viol_count(viol_count_o[2]), .txn_count(txn_count_o[2]), .fsm_state(fsm_state_o[2]));

  fp_flag_monitor #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o[3]),
    .a(a), .b(b), .c(c), .result(result), .flags(flags),
    .fflags_clr(fflags_clr), .viol_ack(viol_ack), .fflags(fflags_o[3]),
    .viol_valid(viol_valid_o[3]), .viol_code(viol_code_o[3]), .viol_result(viol_result_o[3]),
    .viol_count(viol_count3), .txn_count(txn_count3), .fsm_state(fsm_state_o[3]));

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0; fflags_clr = 1'b0; viol_ack = 1'b0;
    a = '0; b = '0; c = '0; result = '0; flags = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] ta, input logic [31:0] tb_v, input logic [31:0] tc,
                       input logic [31:0] tr, input logic [4:0] tf);
    a = ta; b = tb_v; c = tc; result = tr; flags = tf; in_valid = 1'b1;
  endtask

  task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic [31:0] tc,
                      input logic [31:0] tr, input logic [4:0] tf);
    drive(ta, tb_v, tc, tr, tf);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic        rtz;
    logic [31:0] va, vb, vc, vr;
    logic [4:0]  fl;
    logic        viol;
    logic [3:0]  code;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int d;
    vecs[0]  = '{1'b0, 32'h7F800001, 32'h0, 32'h0, 32'h7FC00000, 5'b10000, 1'b0, 4'd0};
    vecs[1]  = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h7F800000, 5'b00100, 1'b1, 4'd5};
    vecs[2]  = '{1'b1, 32'h0, 32'h0, 32'h0, 32'h7F800000, 5'b00101, 1'b1, 4'd7};
    vecs[3]  = '{1'b1, 32'h0, 32'h0, 32'h0, 32'h7F7FFFFF, 5'b00101, 1'b0, 4'd0};
    vecs[4]  = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h00000001, 5'b00001, 1'b1, 4'd10};
    vecs[5]  = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h00000001, 5'b00011, 1'b0, 4'd0};
    vecs[6]  = '{1'b0, 32'h3F800000, 32'h7FC00000, 32'h0, 32'h3F800000, 5'b00000, 1'b1, 4'd0};
    vecs[7]  = '{1'b0, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 5'b10000, 1'b1, 4'd2};
    vecs[8]  = '{1'b0, 32'h3F800000, 32'h0, 32'h0, 32'h3F800000, 5'b01000, 1'b1, 4'd3};
    vecs[9]  = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h7F800000, 5'b10000, 1'b1, 4'd4};
    vecs[10] = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h00000001, 5'b00010, 1'b1, 4'd6};
    vecs[11] = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h00000000, 5'b00011, 1'b1, 4'd8};
    vecs[12] = '{1'b0, 32'h0, 32'h0, 32'h0, 32'hFF800000, 5'b00001, 1'b1, 4'd9};
    vecs[13] = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h7F7FFFFF, 5'b00101, 1'b1, 4'd7};
    vecs[14] = '{1'b0, 32'h7F800001, 32'h0, 32'h0, 32'h3F800000, 5'b00000, 1'b1, 4'd0};

    // Reset values, including in_ready low while reset is held.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("in_ready_during_reset", 32'(in_ready_o[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) check("reset_in_ready", 32'(in_ready_o[k]), 1);
    check("reset_fflags", 32'(fflags_o[0]), 0);
    check("reset_viol_valid", 32'(viol_valid_o[0]), 0);
    check("reset_viol_code", 32'(viol_code_o[0]), 0);
    check("reset_viol_result", viol_result_o[0], 0);
    check("reset_viol_count", 32'(viol_count_o[0]), 0);
    check("reset_txn_count", 32'(txn_count_o[0]), 0);
    check("reset_fsm_state", 32'(fsm_state_o[1]), 0);

    // Single-transaction rule vectors.
    for (int i = 0; i < 15; i++) begin
      d = vecs[i].rtz ? 2 : 0;
      do_reset();
      send(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].vr, vecs[i].fl);
      @(negedge clk);
      check($sformatf("v%0d_latency_fflags", i), 32'(fflags_o[d]), 0);
      check($sformatf("v%0d_latency_txn", i), 32'(txn_count_o[d]), 0);
      @(negedge clk);
      check($sformatf("v%0d_viol_valid", i), 32'(viol_valid_o[d]), 32'(vecs[i].viol));
      check($sformatf("v%0d_viol_code", i), 32'(viol_code_o[d]), 32'(vecs[i].code));
      check($sformatf("v%0d_viol_result", i), viol_result_o[d], vecs[i].viol ? vecs[i].vr : 32'h0);
      check($sformatf("v%0d_viol_count", i), 32'(viol_count_o[d]), 32'(vecs[i].viol));
      check($sformatf("v%0d_fflags", i), 32'(fflags_o[d]), 32'(vecs[i].fl));
      check($sformatf("v%0d_txn_count", i), 32'(txn_count_o[d]), 1);
    end

    // Halt on violation: txn in stage 1 completes, the third is refused until ack.
    do_reset();
    drive(32'h0, 32'h0, 32'h0, 32'h7F800000, 5'b00100);
    @(negedge clk);
    drive(32'h0, 32'h0, 32'h0, 32'h3F800000, 5'b00000);
    @(negedge clk);
    check("halt_stall_in_ready", 32'(in_ready_o[1]), 0);
    check("nohalt_in_ready", 32'(in_ready_o[0]), 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("halt_in_ready_halted", 32'(in_ready_o[1]), 0);
    check("halt_fsm_state", 32'(fsm_state_o[1]), 1);
    check("halt_viol_valid", 32'(viol_valid_o[1]), 1);
    check("halt_viol_code", 32'(viol_code_o[1]), 5);
    repeat (3) @(negedge clk);
    check("halt_txn_count", 32'(txn_count_o[1]), 2);
    check("nohalt_txn_count", 32'(txn_count_o[0]), 3);
    check("halt_still_stalled", 32'(in_ready_o[1]), 0);
    viol_ack = 1'b1;
    @(negedge clk);
    viol_ack = 1'b0;
    check("halt_ack_in_ready", 32'(in_ready_o[1]), 1);
    check("halt_ack_viol_valid", 32'(viol_valid_o[1]), 0);
    check("halt_ack_fsm_state", 32'(fsm_state_o[1]), 0);

    // Back-to-back violations: capture keeps the first, count sees all four.
    do_reset();
    drive(32'h0, 32'h0, 32'h0, 32'h7F800000, 5'b00100);
    @(negedge clk);
    drive(32'h0, 32'h0, 32'h0, 32'h00000001, 5'b00001);
    @(negedge clk);
    drive(32'h0, 32'h0, 32'h0, 32'hFF800000, 5'b00001);
    @(negedge clk);
    drive(32'h0, 32'h0, 32'h0, 32'h00000001, 5'b00010);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("b2b_viol_count", 32'(viol_count_o[0]), 4);
    check("b2b_txn_count", 32'(txn_count_o[0]), 4);
    check("b2b_viol_code", 32'(viol_code_o[0]), 5);
    check("b2b_viol_result", viol_result_o[0], 32'h7F800000);
    check("b2b_fflags", 32'(fflags_o[0]), 32'b00111);
    send(32'h0, 32'h0, 32'h0, 32'h3F800001, 5'b00001);
    @(negedge clk);
    fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
    check("clr_with_update_fflags", 32'(fflags_o[0]), 32'b00001);
    check("clr_with_update_viol_count", 32'(viol_count_o[0]), 4);

    // Counter saturation at CNT_W=4.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(32'h0, 32'h0, 32'h0, 32'h3F800000, 5'b00000);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("sat_txn_count_w4", 32'(txn_count3), 15);
    check("txn_count_w16", 32'(txn_count_o[0]), 20);

    // Asynchronous reset in the middle of a stream.
    drive(32'h0, 32'h0, 32'h0, 32'h7F800000, 5'b00100);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive(32'h0, 32'h0, 32'h0, 32'h3F800001, 5'b00001);
      @(negedge clk);
    end
    check("pre_rst_viol_valid", 32'(viol_valid_o[0]), 1);
    check("pre_rst_fsm_state", 32'(fsm_state_o[1]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready_o[0]), 0);
    check("arst_fflags", 32'(fflags_o[0]), 0);
    check("arst_viol_valid", 32'(viol_valid_o[0]), 0);
    check("arst_viol_code", 32'(viol_code_o[0]), 0);
    check("arst_viol_result", viol_result_o[0], 0);
    check("arst_viol_count", 32'(viol_count_o[0]), 0);
    check("arst_txn_count", 32'(txn_count_o[0]), 0);
    check("arst_fsm_state", 32'(fsm_state_o[1]), 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_txn_count", 32'(txn_count_o[0]), 0);
    check("post_rst_fflags", 32'(fflags_o[0]), 0);
    check("post_rst_in_ready", 32'(in_ready_o[1]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_flag_monitor.md
# fp_flag_monitor

Parametrised, pipelined IEEE-754 exception-flag monitor for the symfpu datapath. It accepts one (operands, result, flags) transaction per cycle over a valid/ready handshake and classifies all four values. It checks eleven flag/result consistency rules and accumulates sticky RISC-V-style fflags. It counts and captures violations and can optionally stall the stream on the first violation. It sits between the FPU output and the bench scoreboard and generalises the combinational float32 edge checks to any format, all rounding modes and three operands.

## Interface
- EXP_W, 8, exponent width
- FRAC_W, 23, stored fraction width; W = 1+EXP_W+FRAC_W
- RMODE, 0, rounding mode: 0 RNE, 1 RNA, 2 RTP, 3 RTN, 4 RTZ
- RULE_EN, 11'h7FF, per-rule enable mask (bit k = rule Rk)
- HALT_ON_VIOL, 0, 1 = deassert in_ready after a violation until acknowledged
- CNT_W, 16, width of the saturating counters
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  transaction valid
- in_ready  out  1  monitor can accept
- a, b, c  in  W each  operands; unused operands are driven to +0
- result  in  W  FPU result
- flags  in  5  {NV,DZ,OF,UF,NX}
- fflags_clr  in  1  clear sticky flags
- viol_ack  in  1  release capture and HALTED state
- fflags  out  5  sticky OR of accepted flags
- viol_valid  out  1  capture register holds a violation
- viol_code  out  4  rule index of the captured violation
- viol_result  out  W  result of the captured transaction
- viol_count  out  CNT_W  total violations, saturating
- txn_count  out  CNT_W  checked transactions, saturating

## Operation
- Classification per value uses exp==0, exp==all-ones and frac==0, frac MSB. Classes: zero, subnormal, normal, inf, qNaN (frac MSB=1), sNaN (frac MSB=0, frac≠0). maxfin = exp all-ones-minus-1, frac all-ones.
- Rules: R0 any operand NaN → result NaN.
- R1 any operand sNaN → NV.
- R2 all three operands qNaN → !NV.
- R3 DZ → result inf.
- R4 NV → result qNaN.
- R5 OF → NX.
- R6 UF → NX.
- R7 OF → result by RMODE: RNE/RNA ±inf; RTP +inf or −maxfin; RTN +maxfin or −inf; RTZ ±maxfin.
- R8 UF → result subnormal.
- R9 result inf && !OF → !NX.
- R10 result subnormal && !UF → !NX.
- Masked rules never fire. With several failing rules, the lowest index is reported.
- fflags: next = (fflags_clr ? 0 : fflags) | stage-2 flags. A simultaneous clear and update keeps the new flags.
- Capture: the first violation while viol_valid=0 loads viol_code/viol_result and sets viol_valid. Later violations only increment viol_count. viol_ack clears viol_valid. When ack and a new violation coincide, the new one is captured.
- FSM {RUN, HALTED}, used only when HALT_ON_VIOL=1. RUN→HALTED on stage-2 violation; HALTED→RUN on viol_ack. in_ready = (state==RUN) && !(stage-2 violation this cycle). With HALT_ON_VIOL=0, in_ready is constantly 1.
- Counters saturate at all-ones and never wrap.

## Timing
- Stage 1 registers the accepted transaction and its classes. Stage 2 registers the rule results and all state.
- A transaction accepted at edge N updates fflags, the counters and the capture register at edge N+2.
- A transaction already in stage 1 when HALTED is entered still completes and is counted. Nothing new is accepted while in_ready=0.
- Reset: in_ready=1 after reset (0 during reset), fflags=0, viol_valid=0, viol_code=0, viol_result=0, counters=0, FSM=RUN, pipeline valids cleared. Reset mid-transaction discards in-flight data.

## Structure
- Package fp_mon_pkg: rounding-mode enum, rule-index constants R0..R10, flag bit positions, the class struct and the parametrised classify function.
- One sub-module fp_classify (EXP_W, FRAC_W), instantiated four times in stage 1.

## Test plan
- float32 RNE: a=0x7F800001 (sNaN), result=0x7FC00000, flags=NV → no violation; fflags=5'b10000 at N+2; txn_count=1.
- flags=OF only, result=0x7F800000 → viol_code=5 (R5), viol_count=1; with HALT_ON_VIOL=1, in_ready low until viol_ack.
- RMODE=RTZ: result=0x7F800000, flags=OF|NX → viol_code=7. The same stimulus with result=0x7F7FFFFF gives no violation.
- result=0x00000001, flags=NX (no UF) → R10. With flags=UF|NX → clean.
- Back-to-back stream of 4 violating transactions with HALT_ON_VIOL=0 → viol_count=4, capture holds the first; fflags_clr coinciding with a NX transaction gives fflags=5'b00001.
- CNT_W=4: drive 20 transactions → txn_count saturates at 15. Assert rst_n low mid-stream → all outputs return to reset values asynchronously.
